// File: rtl/sobel_stream_if.sv
// sobel_stream_if: gray pixel stream into the Sobel core and edge magnitude stream out.
interface sobel_stream_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic                   start_i;
  logic                   px_valid_i;
  logic [PIXEL_WIDTH-1:0] in_px_gray_i;
  logic [PIXEL_WIDTH-1:0] out_px_sobel_o;
  logic                   out_valid_o;
  modport master (output start_i, px_valid_i, in_px_gray_i, input out_px_sobel_o, out_valid_o);
  modport slave (input start_i, px_valid_i, in_px_gray_i, output out_px_sobel_o, out_valid_o);
endinterface

// File: rtl/sobel_stream_core.sv
// sobel_stream_core: streaming 3x3 Sobel magnitude over a raster gray image using two line buffers.
module sobel_stream_core #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 16
) (
  input  logic         clk_i,
  input  logic         nreset_i,
  sobel_stream_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int GW = PIXEL_WIDTH + 3;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t                                 state_q, state_d;
  logic [CW-1:0]                          col_q, col_d;
  logic [1:0]                             row_q, row_d;
  logic [2:0][2:0][PIXEL_WIDTH-1:0]       p_q, p_d, p_sh;
  logic [PIXEL_WIDTH-1:0]                 out_q, out_d;
  logic                                   ov_q, ov_d;
  logic [PIXEL_WIDTH-1:0]                 lb0_q [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0]                 lb1_q [IMG_WIDTH];
  logic                                   accept, last_col, win_ok;
  logic signed [GW-1:0]                   w [3][3];
  logic signed [GW-1:0]                   gx, gy;
  logic [GW-1:0]                          ax, ay, mag;
  logic [PIXEL_WIDTH-1:0]                 sat;
  assign accept   = bus.start_i & bus.px_valid_i;
  assign last_col = col_q == CW'(IMG_WIDTH - 1);
  // row_q saturates at 2, so it reads 2 for every row from the third one on
  assign win_ok   = accept && row_q == 2'd2 && col_q >= CW'(2);
  always_comb begin
    p_sh = '0;
    for (int r = 0; r < 3; r++) begin
      p_sh[r][0] = p_q[r][1];
      p_sh[r][1] = p_q[r][2];
    end
    p_sh[0][2] = lb0_q[col_q];
    p_sh[1][2] = lb1_q[col_q];
    p_sh[2][2] = bus.in_px_gray_i;
  end
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[r][c] = $signed({3'b000, p_sh[r][c]});
    gx  = (w[0][2] + w[1][2] + w[1][2] + w[2][2]) - (w[0][0] + w[1][0] + w[1][0] + w[2][0]);
    gy  = (w[2][0] + w[2][1] + w[2][1] + w[2][2]) - (w[0][0] + w[0][1] + w[0][1] + w[0][2]);
    ax  = gx[GW-1] ? -gx : gx;
    ay  = gy[GW-1] ? -gy : gy;
    mag = ax + ay;
    sat = |mag[GW-1:PIXEL_WIDTH] ? '1 : mag[PIXEL_WIDTH-1:0];
  end
  always_comb begin
    state_d = !bus.start_i ? IDLE :
              state_q == IDLE ? FILL :
              (state_q == FILL && accept && row_q == 2'd2) ? RUN : state_q;
    col_d   = !bus.start_i ? '0 : accept ? (last_col ? '0 : col_q + CW'(1)) : col_q;
    row_d   = !bus.start_i ? '0 : (accept && last_col && row_q != 2'd2) ? row_q + 2'd1 : row_q;
    p_d     = !bus.start_i ? '0 : accept ? p_sh : p_q;
    out_d   = win_ok ? sat : out_q;
    ov_d    = win_ok;
  end
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      p_q     <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      p_q     <= p_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end
  // buf0 holds row r-2, buf1 row r-1; contents are refilled after every restart
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= bus.in_px_gray_i;
    end
  end
  assign bus.out_px_sobel_o = out_q;
  assign bus.out_valid_o    = ov_q;
endmodule

// File: tb/tb_sobel_stream_core.sv
// tb_sobel_stream_core: table-driven frames checked against a direct 2D Sobel model via a scoreboard queue.
module tb_sobel_stream_core;
  localparam int W = 16;
  typedef struct {int val; int due;} exp_t;
  typedef struct {int kind; int rows; bit stall; int exp_cnt; int exp_val;} vec_t;
  logic clk = 0;
  logic nreset = 1;
  always #5 clk = ~clk;
  sobel_stream_if #(.PIXEL_WIDTH(8)) bus ();
  sobel_stream_core #(.PIXEL_WIDTH(8), .IMG_WIDTH(W)) dut (.clk_i(clk), .nreset_i(nreset), .bus(bus));
  exp_t q[$];
  exp_t e;
  vec_t vt[7];
  int img[8][W];
  int tests = 0, fails = 0, cyc = 0, n_out = 0, cur_const = -1;
  int last_out = 0;
  bit prev_acc = 0;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic int sobel(input int r, input int c);
    int gx, gy, m;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return m > 255 ? 255 : m;
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_acc <= nreset && bus.start_i && bus.px_valid_i;
  end
  always @(negedge clk) begin
    if (!nreset) begin
      q.delete();
      last_out = 0;
      check("reset_valid", bus.out_valid_o, 0);
      check("reset_px", bus.out_px_sobel_o, 0);
    end else if (bus.out_valid_o) begin
      n_out++;
      check("valid_without_accept", prev_acc, 1);
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %0d with empty scoreboard", bus.out_px_sobel_o);
      end else begin
        e = q.pop_front();
        check("latency", cyc, e.due);
        check("pixel", bus.out_px_sobel_o, e.val);
        if (cur_const >= 0) check("pattern_const", bus.out_px_sobel_o, cur_const);
      end
      last_out = bus.out_px_sobel_o;
    end else check("hold", bus.out_px_sobel_o, last_out);
  end
  task automatic px(input bit s, input bit v, input int d);
    @(negedge clk);
    bus.start_i = s;
    bus.px_valid_i = v;
    bus.in_px_gray_i = 8'(d);
  endtask
  task automatic run_frame(input int kind, input int rows, input bit stall, input int npix);
    int k = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = kind == 0 ? 100 : kind == 1 ? c : kind == 2 ? r*10 :
                    kind == 3 ? (c < 8 ? 0 : 255) : int'($urandom_range(0, 255));
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < W; c++) begin
        if (r*W + c >= npix) return;
        if (stall && k % 5 == 4) repeat (3) px(1, 0, 0);
        k++;
        px(1, 1, img[r][c]);
        if (r >= 2 && c >= 2) q.push_back('{sobel(r, c), cyc + 1});
      end
    px(1, 0, 0);
  endtask
  task automatic finish_frame(input int exp_cnt);
    px(0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    check("output_count", n_out, exp_cnt);
    n_out = 0;
  endtask
  initial begin
    bus.start_i = 0;
    bus.px_valid_i = 0;
    bus.in_px_gray_i = 0;
    vt = '{'{0, 4, 0, 28, 0}, '{1, 4, 0, 28, 8}, '{2, 5, 0, 42, 80}, '{3, 4, 0, 28, -1},
           '{1, 4, 1, 28, 8}, '{4, 6, 0, 56, -1}, '{4, 3, 1, 14, -1}};
    #1 nreset = 0;
    repeat (3) @(posedge clk);
    #1 nreset = 1;
    repeat (2) @(negedge clk);
    foreach (vt[i]) begin
      n_out = 0;
      cur_const = vt[i].exp_val;
      run_frame(vt[i].kind, vt[i].rows, vt[i].stall, 1000);
      finish_frame(vt[i].exp_cnt);
      cur_const = -1;
    end
    n_out = 0;
    run_frame(1, 4, 0, 37);
    px(0, 1, 99);
    @(posedge clk);
    #1 check("abort_valid", bus.out_valid_o, 0);
    finish_frame(3);
    cur_const = 8;
    run_frame(1, 4, 0, 1000);
    finish_frame(28);
    cur_const = -1;
    run_frame(2, 5, 0, 40);
    @(posedge clk);
    #1 nreset = 0;
    #1 check("reset_immediate_valid", bus.out_valid_o, 0);
    check("reset_immediate_px", bus.out_px_sobel_o, 0);
    bus.start_i = 0;
    bus.px_valid_i = 0;
    repeat (2) @(posedge clk);
    #1 nreset = 1;
    repeat (3) @(negedge clk);
    n_out = 0;
    cur_const = 80;
    run_frame(2, 5, 0, 1000);
    finish_frame(42);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
